// File: rtl/cpu_pkg.sv
// Shared definitions for the lab CPU instruction issuer: opcode/op constants,
// instruction field positions and the issuer state encoding.
package cpu_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  // LSB positions of each field inside the 16-bit instruction word
  localparam int OPC_LSB   = 13;
  localparam int OP_LSB    = 11;
  localparam int RN_LSB    = 8;
  localparam int RD_LSB    = 5;
  localparam int SHIFT_LSB = 3;
  localparam int RM_LSB    = 0;
  localparam int IMM8_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DROP  = 3'd3,
    ST_DONE  = 3'd4,
    ST_RESP  = 3'd5
  } issuer_state_e;

endpackage

// File: rtl/instr_encoder.sv
// Combinational fields-to-word encoder for the lab CPU instruction format.
// MOV Rn,#imm8 packs imm8 into the low byte; MOV Rd,Rm forces the Rn field to 0.
import cpu_pkg::*;

module instr_encoder (
  input  logic [2:0]  opcode_i,
  input  logic [1:0]  op_i,
  input  logic [2:0]  rn_i,
  input  logic [2:0]  rd_i,
  input  logic [1:0]  shift_i,
  input  logic [2:0]  rm_i,
  input  logic [7:0]  imm8_i,
  output logic [15:0] word_o
);

  always_comb begin
    word_o = '0;
    word_o[OPC_LSB +: 3] = opcode_i;
    word_o[OP_LSB +: 2]  = op_i;
    if (opcode_i == OPC_MOV && op_i == OP_MOVI) begin
      word_o[RN_LSB +: 3]   = rn_i;
      word_o[IMM8_LSB +: 8] = imm8_i;
    end else begin
      if (!(opcode_i == OPC_MOV && op_i == OP_MOVR)) begin
        word_o[RN_LSB +: 3] = rn_i;
      end
      word_o[RD_LSB +: 3]    = rd_i;
      word_o[SHIFT_LSB +: 2] = shift_i;
      word_o[RM_LSB +: 3]    = rm_i;
    end
  end

endmodule

// File: rtl/cpu_instr_issuer.sv
// Issues one encoded instruction to the lab CPU via load/start and returns the result.
// Optional busy-phase timeout is built when CPU_ISSUER_TIMEOUT_EN is defined.
import cpu_pkg::*;

module cpu_instr_issuer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_opcode,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_rn,
  input  logic [2:0]  cmd_rd,
  input  logic [1:0]  cmd_shift,
  input  logic [2:0]  cmd_rm,
  input  logic [7:0]  cmd_imm8,
  output logic [15:0] cpu_in,
  output logic        cpu_load,
  output logic        cpu_s,
  input  logic        cpu_w,
  input  logic [15:0] cpu_out,
  input  logic        cpu_N,
  input  logic        cpu_V,
  input  logic        cpu_Z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_word,
  output logic [15:0] rsp_out,
  output logic [2:0]  rsp_nvz,
  output logic        rsp_err
);

  issuer_state_e state_q, state_d;
  logic [15:0]   word_q, word_d;
  logic [15:0]   out_q, out_d;
  logic [2:0]    nvz_q, nvz_d;
  logic          err_q, err_d;
  logic [15:0]   enc_word;
  logic          timeout_hit;

  instr_encoder u_enc (
    .opcode_i (cmd_opcode),
    .op_i     (cmd_op),
    .rn_i     (cmd_rn),
    .rd_i     (cmd_rd),
    .shift_i  (cmd_shift),
    .rm_i     (cmd_rm),
    .imm8_i   (cmd_imm8),
    .word_o   (enc_word)
  );

`ifdef CPU_ISSUER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts cycles spent in DROP and DONE; cleared while entering DROP from START
  always_comb begin
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    if (state_q == ST_START) begin
      cnt_d = '0;
    end else if (state_q == ST_DROP || state_q == ST_DONE) begin
      cnt_d       = cnt_q + 1'b1;
      timeout_hit = (cnt_d == CNT_W'(TIMEOUT));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    out_d   = out_q;
    nvz_d   = nvz_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          word_d  = enc_word;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:  if (cpu_w) state_d = ST_START;
      ST_START: state_d = ST_DROP;
      ST_DROP: begin
        if (!cpu_w) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          out_d   = '0;
          nvz_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_DONE: begin
        // A real completion on the final allowed cycle wins over the timeout
        if (cpu_w) begin
          out_d   = cpu_out;
          nvz_d   = {cpu_N, cpu_V, cpu_Z};
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          out_d   = '0;
          nvz_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      out_q   <= '0;
      nvz_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      out_q   <= out_d;
      nvz_q   <= nvz_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign cpu_load  = (state_q == ST_LOAD) && cpu_w;
  assign cpu_s     = (state_q == ST_START);
  assign cpu_in    = word_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_word  = word_q;
  assign rsp_out   = out_q;
  assign rsp_nvz   = nvz_q;
  assign rsp_err   = err_q;

endmodule
